el2_lsu_dbus_resp: RTL and testbench

- Bus-side responder for external (non-DCCM, non-PIC) LSU data accesses; it is the target end of the LSU external request path.
- Accepts one request at a time and decodes it against its own address window.
- Checks size and alignment, performs a read or write on a small word-organised register store, and returns a tagged response with error and mscause after a programmable latency.
- Used as a memory-mapped peripheral model and as a side-effect target for LSU bring-up.

---
 rtl/el2_pkg.sv | 36 +++
 rtl/el2_lsu_dbus_resp_mem.sv | 36 +++
 rtl/el2_lsu_dbus_resp.sv | 212 +++++++++++++++++++++
 tb/tb_el2_lsu_dbus_resp.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared types and constants for the LSU external data-bus responder.
// Request/response bundles, FSM state encoding, size and mscause codes.
package el2_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [3:0] MSC_NONE     = 4'h0;
  localparam logic [3:0] MSC_MISALIGN = 4'h1;
  localparam logic [3:0] MSC_RANGE    = 4'h3;
  localparam logic [3:0] MSC_SIZE     = 4'h6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } el2_dbus_state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  tag;
  } el2_dbus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic [3:0]  mscause;
    logic [2:0]  tag;
  } el2_dbus_resp_t;

endpackage

// File: rtl/el2_lsu_dbus_resp_mem.sv
// Word-organised register store for the data-bus responder.
// Byte-enable write, combinational read, synchronous clear on rst.
module el2_lsu_dbus_resp_mem #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [DEPTH];

  // Clear every word on reset, otherwise merge enabled bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/el2_lsu_dbus_resp.sv
// Target end of the LSU external request path: decode, access, tagged response.
// Optional error injection input enabled by RV_DBUS_RESP_ERRINJ_EN.
module el2_lsu_dbus_resp
  import el2_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          DEPTH_LOG2 = 4,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef RV_DBUS_RESP_ERRINJ_EN
  input  logic        err_inj,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_tag,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [3:0]  resp_mscause,
  output logic [2:0]  resp_tag,
  output logic        busy
);

  localparam logic [31:0] WMASK =
    (32'd1 << (DEPTH_LOG2 + 2)) - 32'd1;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  el2_dbus_state_e r_state;
  el2_dbus_req_t   r_req;
  el2_dbus_resp_t  r_resp;
  logic [3:0]      r_cnt;
  logic            r_inj;
  logic            r_ready;
  logic            r_resp_valid;
  logic            r_busy;

  el2_dbus_req_t   w_req;
  el2_dbus_resp_t  w_resp_n;
  logic            w_idle;
  logic            w_inj_in;
  logic            w_inj;
  logic [3:0]      w_cause;
  logic            w_err;
  logic            w_misal;
  logic            w_out;
  logic [3:0]      w_be;
  logic [31:0]     w_wd;
  logic [31:0]     w_word;
  logic [31:0]     w_sh;
  logic [31:0]     w_ld;
  logic            w_enter;
  logic            w_we;

`ifdef RV_DBUS_RESP_ERRINJ_EN
  assign w_inj_in = err_inj;
`else
  assign w_inj_in = 1'b0;
`endif

  assign w_idle = (r_state == ST_IDLE);

  // Fields in IDLE come straight from the bus so LATENCY=0 can respond next edge
  always_comb begin
    w_req = r_req;
    w_inj = r_inj;
    if (w_idle) begin
      w_req.write = req_write;
      w_req.size  = req_size;
      w_req.addr  = req_addr;
      w_req.wdata = req_wdata;
      w_req.tag   = req_tag;
      w_inj       = w_inj_in;
    end
  end

  assign w_misal =
    ((w_req.size == SZ_HALF) && w_req.addr[0]) ||
    ((w_req.size == SZ_WORD) && (w_req.addr[1:0] != 2'b00));
  assign w_out = ((w_req.addr & ~WMASK) != BASE_ADDR);

  // Prioritised error decode, injection first
  always_comb begin
    w_cause = MSC_NONE;
    if (w_inj) begin
      w_cause = MSC_MISALIGN;
    end else if (w_req.size == SZ_ILL) begin
      w_cause = MSC_SIZE;
    end else if (w_misal) begin
      w_cause = MSC_MISALIGN;
    end else if (w_out) begin
      w_cause = MSC_RANGE;
    end
  end

  assign w_err = (w_cause != MSC_NONE);

  // Byte lanes and lane-aligned data for the store, shifted load data
  always_comb begin
    w_be = 4'b1111;
    w_ld = w_sh;
    case (w_req.size)
      SZ_BYTE: begin
        w_be = 4'b0001 << w_req.addr[1:0];
        w_ld = {24'b0, w_sh[7:0]};
      end
      SZ_HALF: begin
        w_be = 4'b0011 << w_req.addr[1:0];
        w_ld = {16'b0, w_sh[15:0]};
      end
      default: begin
        w_be = 4'b1111;
        w_ld = w_sh;
      end
    endcase
  end

  assign w_wd = w_req.wdata << {w_req.addr[1:0], 3'b000};
  assign w_sh = w_word >> {w_req.addr[1:0], 3'b000};

  assign w_enter = !rst && (
    (w_idle && req_valid && (LAT4 == 4'd0)) ||
    ((r_state == ST_WAIT) && (r_cnt == 4'd1)));
  assign w_we = w_enter && w_req.write && !w_err;

  assign w_resp_n.rdata   = (w_err || w_req.write) ? 32'd0 : w_ld;
  assign w_resp_n.error   = w_err;
  assign w_resp_n.mscause = w_cause;
  assign w_resp_n.tag     = w_req.tag;

  el2_lsu_dbus_resp_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_idx   (w_req.addr[DEPTH_LOG2+1:2]),
    .i_wdata (w_wd),
    .o_rdata (w_word)
  );

  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_resp       <= '0;
      r_cnt        <= '0;
      r_inj        <= 1'b0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req   <= w_req;
            r_inj   <= w_inj;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (LAT4 == 4'd0) begin
              r_state      <= ST_RESP;
              r_resp       <= w_resp_n;
              r_resp_valid <= 1'b1;
              r_cnt        <= '0;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= LAT4;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state      <= ST_RESP;
            r_resp       <= w_resp_n;
            r_resp_valid <= 1'b1;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_ready & ~rst;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp.rdata;
  assign resp_error   = r_resp.error;
  assign resp_mscause = r_resp.mscause;
  assign resp_tag     = r_resp.tag;
  assign busy         = r_busy;

endmodule

// File: tb/tb_el2_lsu_dbus_resp.sv
// Directed bench for el2_lsu_dbus_resp (LATENCY=2 and LATENCY=0 instances).
// Error-injection scenario compiled in with RV_DBUS_RESP_ERRINJ_EN.
module tb_el2_lsu_dbus_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_write = 0, resp_ready = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0]  req_tag = 0;
  logic        req_ready, resp_valid, resp_error, busy;
  logic [31:0] resp_rdata;
  logic [3:0]  resp_mscause;
  logic [2:0]  resp_tag;

  logic        z_valid = 0, z_write = 0, z_rready = 0;
  logic [1:0]  z_size = 0;
  logic [31:0] z_addr = 0, z_wdata = 0;
  logic [2:0]  z_tag = 0;
  logic        z_ready, z_rvalid, z_error, z_busy;
  logic [31:0] z_rdata;
  logic [3:0]  z_msc;
  logic [2:0]  z_rtag;

`ifdef RV_DBUS_RESP_ERRINJ_EN
  logic err_inj = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  el2_lsu_dbus_resp #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
`ifdef RV_DBUS_RESP_ERRINJ_EN
    .err_inj(err_inj),
`endif
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .resp_mscause(resp_mscause),
    .resp_tag(resp_tag), .busy(busy)
  );

  el2_lsu_dbus_resp #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
`ifdef RV_DBUS_RESP_ERRINJ_EN
    .err_inj(1'b0),
`endif
    .req_valid(z_valid), .req_ready(z_ready),
    .req_write(z_write), .req_size(z_size),
    .req_addr(z_addr), .req_wdata(z_wdata),
    .req_tag(z_tag), .resp_valid(z_rvalid),
    .resp_ready(z_rready), .resp_rdata(z_rdata),
    .resp_error(z_error), .resp_mscause(z_msc),
    .resp_tag(z_rtag), .busy(z_busy)
  );

  // Drive one request and count edges from accept to resp_valid
  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, output int cyc);
    int g;
    @(negedge clk);
    req_valid = 1; req_write = w; req_size = sz;
    req_addr = a; req_wdata = d; req_tag = t;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 req_valid = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 30);
  endtask

  task automatic ack();
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_error, busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 0000",
               {req_ready, resp_valid, resp_error, busy});
    end
    n_cmp++;
    if ({resp_rdata, resp_mscause, resp_tag} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0",
               {resp_rdata, resp_mscause, resp_tag});
    end
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word_rw();
    int cyc;
    issue(1, 2'd2, 32'hF000_0008, 32'hDEADBEEF, 3'd5, cyc);
    n_cmp++;
    if (cyc !== 3 || resp_error !== 1'b0 || resp_tag !== 3'd5) begin
      n_bad++;
      $display("FAIL word_store: lat %0d err %b tag %0d want 3 0 5",
               cyc, resp_error, resp_tag);
    end
    ack();
    issue(0, 2'd2, 32'hF000_0008, 32'h0, 3'd5, cyc);
    n_cmp++;
    if (cyc !== 3 || resp_rdata !== 32'hDEADBEEF ||
        resp_error !== 1'b0 || resp_tag !== 3'd5) begin
      n_bad++;
      $display("FAIL word_load: lat %0d data %h err %b tag %0d want 3 deadbeef 0 5",
               cyc, resp_rdata, resp_error, resp_tag);
    end
    ack();
  endtask

  task automatic test_byte_half();
    int cyc;
    issue(1, 2'd0, 32'hF000_0009, 32'h0000_00A5, 3'd1, cyc);
    ack();
    issue(0, 2'd1, 32'hF000_0008, 32'h0, 3'd2, cyc);
    n_cmp++;
    if (resp_rdata !== 32'h0000_A5EF || resp_error !== 1'b0) begin
      n_bad++;
      $display("FAIL half_load: got %h err %b want 0000a5ef 0",
               resp_rdata, resp_error);
    end
    ack();
    issue(0, 2'd0, 32'hF000_000B, 32'h0, 3'd3, cyc);
    n_cmp++;
    if (resp_rdata !== 32'h0000_00DE || resp_tag !== 3'd3) begin
      n_bad++;
      $display("FAIL byte_load: got %h tag %0d want 000000de 3",
               resp_rdata, resp_tag);
    end
    ack();
  endtask

  task automatic test_errors();
    int cyc;
    issue(0, 2'd1, 32'hF000_0001, 32'h0, 3'd4, cyc);
    n_cmp++;
    if ({resp_error, resp_mscause} !== 5'h11 || resp_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL misalign_half: err %b msc %h data %h want 1 1 0",
               resp_error, resp_mscause, resp_rdata);
    end
    ack();
    issue(1, 2'd2, 32'hF000_0040, 32'h5555_5555, 3'd6, cyc);
    n_cmp++;
    if ({resp_error, resp_mscause} !== 5'h13) begin
      n_bad++;
      $display("FAIL out_window: err %b msc %h want 1 3",
               resp_error, resp_mscause);
    end
    ack();
    issue(0, 2'd2, 32'hF000_0000, 32'h0, 3'd0, cyc);
    n_cmp++;
    if (resp_rdata !== 32'd0 || resp_error !== 1'b0) begin
      n_bad++;
      $display("FAIL suppressed_store: got %h err %b want 0 0",
               resp_rdata, resp_error);
    end
    ack();
    issue(0, 2'd3, 32'h0000_0001, 32'h0, 3'd7, cyc);
    n_cmp++;
    if ({resp_error, resp_mscause} !== 5'h16 || resp_tag !== 3'd7) begin
      n_bad++;
      $display("FAIL illegal_size: err %b msc %h tag %0d want 1 6 7",
               resp_error, resp_mscause, resp_tag);
    end
    ack();
    issue(0, 2'd2, 32'h0000_0002, 32'h0, 3'd1, cyc);
    n_cmp++;
    if (resp_mscause !== 4'h1) begin
      n_bad++;
      $display("FAIL misalign_prio: msc %h want 1", resp_mscause);
    end
    ack();
  endtask

  task automatic test_backpressure();
    int  cyc;
    logic ok;
    issue(0, 2'd2, 32'hF000_0008, 32'h0, 3'd6, cyc);
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (!(resp_valid === 1'b1 && resp_rdata === 32'hDEADA5EF &&
            resp_tag === 3'd6 && resp_error === 1'b0 &&
            resp_mscause === 4'h0 && req_ready === 1'b0 &&
            busy === 1'b1))
        ok = 0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_stable: data %h valid %b ready %b want deadA5ef 1 0",
               resp_rdata, resp_valid, req_ready);
    end
    ack();
    n_cmp++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL ready_after_hs: got %b want 100",
               {req_ready, resp_valid, busy});
    end
  endtask

  task automatic test_latency0();
    @(negedge clk);
    z_valid = 1; z_write = 1; z_size = 2'd2;
    z_addr = 32'hF000_0004; z_wdata = 32'h0BAD_F00D; z_tag = 3'd1;
    @(posedge clk);
    #1 z_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (z_rvalid !== 1'b1 || z_rtag !== 3'd1 || z_error !== 1'b0) begin
      n_bad++;
      $display("FAIL lat0_store: valid %b tag %0d err %b want 1 1 0",
               z_rvalid, z_rtag, z_error);
    end
    z_rready = 1;
    @(posedge clk);
    #1 z_rready = 0;
    @(negedge clk);
    z_valid = 1; z_write = 0; z_tag = 3'd2;
    @(posedge clk);
    #1 z_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (z_rvalid !== 1'b1 || z_rdata !== 32'h0BAD_F00D) begin
      n_bad++;
      $display("FAIL lat0_load: valid %b data %h want 1 0badf00d",
               z_rvalid, z_rdata);
    end
    z_rready = 1;
    @(posedge clk);
    #1 z_rready = 0;
  endtask

  task automatic test_reset_mid();
    int   cyc;
    logic seen;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 2'd2;
    req_addr = 32'hF000_0000; req_wdata = 32'h0000_1234; req_tag = 3'd3;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL in_wait: busy %b valid %b want 1 0", busy, resp_valid);
    end
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_error, busy,
         resp_rdata, resp_mscause, resp_tag} !== 43'd0) begin
      n_bad++;
      $display("FAIL mid_reset_out: ready %b valid %b busy %b data %h",
               req_ready, resp_valid, busy, resp_rdata);
    end
    rst = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abandoned_resp: got valid want none");
    end
    issue(0, 2'd2, 32'hF000_0000, 32'h0, 3'd4, cyc);
    n_cmp++;
    if (cyc !== 3 || resp_rdata !== 32'd0 || resp_error !== 1'b0) begin
      n_bad++;
      $display("FAIL load_after_reset: lat %0d data %h want 3 0",
               cyc, resp_rdata);
    end
    ack();
  endtask

`ifdef RV_DBUS_RESP_ERRINJ_EN
  task automatic test_errinj();
    int cyc;
    issue(1, 2'd2, 32'hF000_0010, 32'h1111_1111, 3'd1, cyc);
    ack();
    err_inj = 1;
    issue(1, 2'd2, 32'hF000_0010, 32'h2222_2222, 3'd2, cyc);
    err_inj = 0;
    n_cmp++;
    if ({resp_error, resp_mscause} !== 5'h11) begin
      n_bad++;
      $display("FAIL errinj_resp: err %b msc %h want 1 1",
               resp_error, resp_mscause);
    end
    ack();
    issue(0, 2'd2, 32'hF000_0010, 32'h0, 3'd3, cyc);
    n_cmp++;
    if (resp_rdata !== 32'h1111_1111 || resp_error !== 1'b0) begin
      n_bad++;
      $display("FAIL errinj_old: data %h err %b want 11111111 0",
               resp_rdata, resp_error);
    end
    ack();
  endtask
`endif

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_errors();
    test_backpressure();
    test_latency0();
    test_reset_mid();
`ifdef RV_DBUS_RESP_ERRINJ_EN
    test_errinj();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
